// File: rtl/frv_mem_pkg.sv
// ----------------------------------------------------------------------------
// frv_mem_pkg
//   Shared definitions for the instruction/data memory arbiter.
//   - owner_e        : one-bit transaction owner ID (imem = 0, dmem = 1)
//   - lock_e         : lock state of the shared request port
//   - OUTSTANDING_MAX: upper bound on in-flight transactions
//   - CNT_W / PTR_W  : widths of the owner FIFO occupancy count and pointers
//   - ptr_inc()      : modulo-depth pointer increment for the owner FIFO
// ----------------------------------------------------------------------------
package frv_mem_pkg;

    typedef enum logic {
        OWNER_IMEM = 1'b0,
        OWNER_DMEM = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_IMEM = 2'd1,
        LOCK_DMEM = 2'd2
    } lock_e;

    localparam int OUTSTANDING_MAX = 4;

    // Count must represent 0..OUTSTANDING_MAX inclusive.
    localparam int CNT_W = 3;
    localparam int PTR_W = 2;

    // Wrap the pointer after the last used slot so any depth 1..4 works
    // without needing a power-of-two storage size.
    function automatic logic [PTR_W-1:0] ptr_inc(
        input logic [PTR_W-1:0] ptr,
        input logic [PTR_W-1:0] last
    );
        return (ptr == last) ? '0 : ptr + 1'b1;
    endfunction

endpackage

// File: rtl/frv_mem_owner_fifo.sv
// ----------------------------------------------------------------------------
// frv_mem_owner_fifo
//   Records which requester owns each granted-but-unanswered transaction so
//   in-order responses can be routed back.
//   Ports:
//     g_clk, g_reset : clock, asynchronous active-high reset
//     i_push         : a request was granted this cycle
//     i_push_id      : owner of that request (0 = imem, 1 = dmem)
//     i_pop          : the head response was accepted this cycle
//     o_head         : owner ID of the oldest outstanding transaction
//     o_count        : number of outstanding transactions (0..DEPTH)
//     o_full/o_empty : occupancy flags
// ----------------------------------------------------------------------------
module frv_mem_owner_fifo
    import frv_mem_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic             g_clk,
    input  logic             g_reset,
    input  logic             i_push,
    input  logic             i_push_id,
    input  logic             i_pop,
    output logic             o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_slot [0:OUTSTANDING_MAX-1];

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_slot[r_rd_ptr];

    // A pop frees a slot in the same cycle, so push is allowed when full
    // only if a pop happens alongside it.
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr, LAST_IDX);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr, LAST_IDX);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Owner IDs are only read while occupied, so the storage needs no reset.
    always_ff @(posedge g_clk) begin
        if (w_push_ok) begin
            r_slot[r_wr_ptr] <= i_push_id;
        end
    end

endmodule

// File: rtl/frv_mem_arbiter.sv
// ----------------------------------------------------------------------------
// frv_mem_arbiter
//   Arbitrates an instruction-fetch port (read-only) and a data port onto one
//   shared request/response port towards the AXI adapter.
//   Parameters:
//     OUTSTANDING   : max granted-but-unanswered transactions (1..4)
//     DATA_PRIORITY : 1 = data port always wins, 0 = round-robin on conflict
//   Ports:
//     g_clk, g_reset            : clock, asynchronous active-high reset
//     imem_req/addr             : fetch request       -> imem_gnt
//     imem_recv/error/rdata     : fetch response      <- imem_ack
//     dmem_req/wen/strb/wdata/addr : data request     -> dmem_gnt
//     dmem_recv/error/rdata     : data response       <- dmem_ack
//     mem_req/wen/strb/wdata/addr : shared request    <- mem_gnt
//     mem_recv/error/rdata      : shared response     -> mem_ack
//   All outputs are held at 0 while g_reset is asserted.
// ----------------------------------------------------------------------------
module frv_mem_arbiter
    import frv_mem_pkg::*;
#(
    parameter int OUTSTANDING   = 2,
    parameter int DATA_PRIORITY = 1
)
(
    input  logic        g_clk,
    input  logic        g_reset,

    input  logic        imem_req,
    input  logic [31:0] imem_addr,
    output logic        imem_gnt,
    output logic        imem_recv,
    input  logic        imem_ack,
    output logic        imem_error,
    output logic [31:0] imem_rdata,

    input  logic        dmem_req,
    input  logic        dmem_wen,
    input  logic [3:0]  dmem_strb,
    input  logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_addr,
    output logic        dmem_gnt,
    output logic        dmem_recv,
    input  logic        dmem_ack,
    output logic        dmem_error,
    output logic [31:0] dmem_rdata,

    output logic        mem_req,
    output logic        mem_wen,
    output logic [3:0]  mem_strb,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_recv,
    output logic        mem_ack,
    input  logic        mem_error,
    input  logic [31:0] mem_rdata
);

    lock_e            r_lock;
    lock_e            w_lock_nxt;
    owner_e           r_last_gnt;

    owner_e           w_sel_free;
    owner_e           w_sel;
    logic             w_sel_dmem;
    logic             w_sel_req;
    logic             w_req_out;
    logic             w_grant;

    logic             w_head;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_head_ack;
    logic             w_ack_out;
    logic             w_pop;

    // ------------------------------------------------------------------
    // Unlocked selection
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_free = OWNER_IMEM;
        if (DATA_PRIORITY != 0) begin
            w_sel_free = dmem_req ? OWNER_DMEM : OWNER_IMEM;
        end else if (imem_req && dmem_req) begin
            // Conflict: whoever was not granted last goes first.
            w_sel_free = (r_last_gnt == OWNER_IMEM) ? OWNER_DMEM : OWNER_IMEM;
        end else begin
            w_sel_free = dmem_req ? OWNER_DMEM : OWNER_IMEM;
        end
    end

    // ------------------------------------------------------------------
    // Lock FSM: once a request is presented without a grant, the shared
    // port is pinned to that owner until the grant arrives so the request
    // fields stay stable for the downstream adapter.
    // ------------------------------------------------------------------
    always_comb begin
        w_lock_nxt = r_lock;
        w_sel      = w_sel_free;

        case (r_lock)
            LOCK_IMEM: w_sel = OWNER_IMEM;
            LOCK_DMEM: w_sel = OWNER_DMEM;
            default:   w_sel = w_sel_free;
        endcase

        w_sel_req = (w_sel == OWNER_DMEM) ? dmem_req : imem_req;
        // Full blocks the request outright, which also keeps the lock
        // from being set while no request is visible downstream.
        w_req_out = w_sel_req && !w_full && !g_reset;
        w_grant   = w_req_out && mem_gnt;

        if (w_grant) begin
            w_lock_nxt = LOCK_NONE;
        end else if (w_req_out) begin
            w_lock_nxt = (w_sel == OWNER_DMEM) ? LOCK_DMEM : LOCK_IMEM;
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_lock <= LOCK_NONE;
        end else begin
            r_lock <= w_lock_nxt;
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_last_gnt <= OWNER_IMEM;
        end else if (w_grant) begin
            r_last_gnt <= w_sel;
        end
    end

    // ------------------------------------------------------------------
    // Owner tracking for in-order response routing
    // ------------------------------------------------------------------
    frv_mem_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .i_push    (w_grant),
        .i_push_id (w_sel == OWNER_DMEM),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Responses arriving with nothing outstanding are stray and dropped.
    assign w_head_ack = w_head ? dmem_ack : imem_ack;
    assign w_ack_out  = (w_count != '0) && w_head_ack && !g_reset;
    assign w_pop      = mem_recv && w_ack_out;

    // ------------------------------------------------------------------
    // Shared request port
    // ------------------------------------------------------------------
    assign w_sel_dmem = (w_sel == OWNER_DMEM) && !g_reset;

    assign mem_req    = w_req_out;
    assign mem_wen    = w_sel_dmem ? dmem_wen   : 1'b0;
    assign mem_strb   = w_sel_dmem ? dmem_strb  : 4'b0;
    assign mem_wdata  = w_sel_dmem ? dmem_wdata : 32'b0;
    assign mem_addr   = g_reset ? 32'b0 : (w_sel_dmem ? dmem_addr : imem_addr);
    assign mem_ack    = w_ack_out;

    assign imem_gnt   = w_grant && (w_sel == OWNER_IMEM);
    assign dmem_gnt   = w_grant && (w_sel == OWNER_DMEM);

    // ------------------------------------------------------------------
    // Response routing: valid goes to the head owner only; data and error
    // are broadcast and only meaningful alongside the matching recv.
    // ------------------------------------------------------------------
    assign imem_recv  = mem_recv && !w_empty && !w_head && !g_reset;
    assign dmem_recv  = mem_recv && !w_empty &&  w_head && !g_reset;

    assign imem_rdata = g_reset ? 32'b0 : mem_rdata;
    assign dmem_rdata = g_reset ? 32'b0 : mem_rdata;
    assign imem_error = mem_error && !g_reset;
    assign dmem_error = mem_error && !g_reset;

endmodule

// File: tb/tb_frv_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_frv_mem_arbiter
//   Two arbiter instances: #0 fixed data priority with 2 outstanding,
//   #1 round-robin with 3 outstanding. Each has its own random requesters
//   and memory side, and is compared every cycle with a transaction-level
//   model (ordered owner list, pending lock owner, last granted owner).
// ----------------------------------------------------------------------------
module tb_frv_mem_arbiter;

    logic clk = 1'b0;
    logic rst;

    logic [1:0]       imem_req, imem_ack, dmem_req, dmem_wen, dmem_ack;
    logic [1:0]       mem_gnt, mem_recv, mem_error;
    logic [1:0][31:0] imem_addr, dmem_wdata, dmem_addr, mem_rdata;
    logic [1:0][3:0]  dmem_strb;

    logic [1:0]       imem_gnt, imem_recv, imem_error;
    logic [1:0]       dmem_gnt, dmem_recv, dmem_error;
    logic [1:0]       mem_req, mem_wen, mem_ack;
    logic [1:0][31:0] imem_rdata, dmem_rdata, mem_wdata, mem_addr;
    logic [1:0][3:0]  mem_strb;

    int n_total = 0;
    int n_bad   = 0;

    // Model state per instance.
    bit m_q    [2][4];   // outstanding owners, oldest at index 0
    int m_cnt  [2];
    int m_lock [2];      // -1 none, 0 imem, 1 dmem
    bit m_last [2];      // owner granted most recently
    bit pend_i [2];
    bit pend_d [2];

    always #5 clk = ~clk;

    frv_mem_arbiter #(.OUTSTANDING(2), .DATA_PRIORITY(1)) dut0 (
        .g_clk(clk), .g_reset(rst),
        .imem_req(imem_req[0]), .imem_addr(imem_addr[0]), .imem_gnt(imem_gnt[0]),
        .imem_recv(imem_recv[0]), .imem_ack(imem_ack[0]), .imem_error(imem_error[0]),
        .imem_rdata(imem_rdata[0]),
        .dmem_req(dmem_req[0]), .dmem_wen(dmem_wen[0]), .dmem_strb(dmem_strb[0]),
        .dmem_wdata(dmem_wdata[0]), .dmem_addr(dmem_addr[0]), .dmem_gnt(dmem_gnt[0]),
        .dmem_recv(dmem_recv[0]), .dmem_ack(dmem_ack[0]), .dmem_error(dmem_error[0]),
        .dmem_rdata(dmem_rdata[0]),
        .mem_req(mem_req[0]), .mem_wen(mem_wen[0]), .mem_strb(mem_strb[0]),
        .mem_wdata(mem_wdata[0]), .mem_addr(mem_addr[0]), .mem_gnt(mem_gnt[0]),
        .mem_recv(mem_recv[0]), .mem_ack(mem_ack[0]), .mem_error(mem_error[0]),
        .mem_rdata(mem_rdata[0])
    );

    frv_mem_arbiter #(.OUTSTANDING(3), .DATA_PRIORITY(0)) dut1 (
        .g_clk(clk), .g_reset(rst),
        .imem_req(imem_req[1]), .imem_addr(imem_addr[1]), .imem_gnt(imem_gnt[1]),
        .imem_recv(imem_recv[1]), .imem_ack(imem_ack[1]), .imem_error(imem_error[1]),
        .imem_rdata(imem_rdata[1]),
        .dmem_req(dmem_req[1]), .dmem_wen(dmem_wen[1]), .dmem_strb(dmem_strb[1]),
        .dmem_wdata(dmem_wdata[1]), .dmem_addr(dmem_addr[1]), .dmem_gnt(dmem_gnt[1]),
        .dmem_recv(dmem_recv[1]), .dmem_ack(dmem_ack[1]), .dmem_error(dmem_error[1]),
        .dmem_rdata(dmem_rdata[1]),
        .mem_req(mem_req[1]), .mem_wen(mem_wen[1]), .mem_strb(mem_strb[1]),
        .mem_wdata(mem_wdata[1]), .mem_addr(mem_addr[1]), .mem_gnt(mem_gnt[1]),
        .mem_recv(mem_recv[1]), .mem_ack(mem_ack[1]), .mem_error(mem_error[1]),
        .mem_rdata(mem_rdata[1])
    );

    function automatic int outs_of(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic bit data_prio(input int i);
        return (i == 0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear(input int i);
        m_cnt[i]  = 0;
        m_lock[i] = -1;
        m_last[i] = 1'b0;
        pend_i[i] = 1'b0;
        pend_d[i] = 1'b0;
    endtask

    task automatic randomize_side(input int i);
        mem_rdata[i] = $urandom;
        mem_error[i] = 1'($urandom_range(1, 0));
        imem_ack[i]  = 1'($urandom_range(1, 0));
        dmem_ack[i]  = 1'($urandom_range(1, 0));
    endtask

    // Requesters hold a request (with stable fields) until it is granted.
    task automatic drive(input int i);
        if (!pend_i[i] && ($urandom_range(1, 0) == 1)) begin
            pend_i[i]    = 1'b1;
            imem_addr[i] = $urandom;
        end
        if (!pend_d[i] && ($urandom_range(2, 0) != 0)) begin
            pend_d[i]     = 1'b1;
            dmem_addr[i]  = $urandom;
            dmem_wdata[i] = $urandom;
            dmem_wen[i]   = 1'($urandom_range(1, 0));
            dmem_strb[i]  = 4'($urandom_range(15, 0));
        end
        imem_req[i] = pend_i[i];
        dmem_req[i] = pend_d[i];
        // The adapter never grants while the arbiter has no room.
        mem_gnt[i]  = (m_cnt[i] < outs_of(i)) ? 1'($urandom_range(1, 0)) : 1'b0;
        mem_recv[i] = ($urandom_range(3, 0) == 0);
        randomize_side(i);
    endtask

    task automatic check_reset(input int i);
        string s;
        s = $sformatf("rst%0d", i);
        chk({s, ".mem_req"},   64'(mem_req[i]),   64'(0));
        chk({s, ".mem_ack"},   64'(mem_ack[i]),   64'(0));
        chk({s, ".mem_wen"},   64'(mem_wen[i]),   64'(0));
        chk({s, ".mem_strb"},  64'(mem_strb[i]),  64'(0));
        chk({s, ".mem_wdata"}, 64'(mem_wdata[i]), 64'(0));
        chk({s, ".mem_addr"},  64'(mem_addr[i]),  64'(0));
        chk({s, ".gnt"},       64'({imem_gnt[i], dmem_gnt[i]}),   64'(0));
        chk({s, ".recv"},      64'({imem_recv[i], dmem_recv[i]}), 64'(0));
        chk({s, ".err"},       64'({imem_error[i], dmem_error[i]}), 64'(0));
        chk({s, ".rdata"},     {imem_rdata[i], dmem_rdata[i]},    64'(0));
    endtask

    task automatic check_cycle(input int i);
        bit    sel, sreq, mreq, grant, head, ack, pop, occ;
        string s;
        s = $sformatf("i%0d", i);

        if (m_lock[i] >= 0)                     sel = (m_lock[i] == 1);
        else if (data_prio(i))                  sel = dmem_req[i];
        else if (imem_req[i] && dmem_req[i])    sel = !m_last[i];
        else                                    sel = dmem_req[i];

        sreq  = sel ? dmem_req[i] : imem_req[i];
        mreq  = sreq && (m_cnt[i] < outs_of(i));
        grant = mreq && mem_gnt[i];
        occ   = (m_cnt[i] != 0);
        head  = m_q[i][0];
        ack   = occ && (head ? dmem_ack[i] : imem_ack[i]);

        chk({s, ".mem_req"},   64'(mem_req[i]),   64'(mreq));
        chk({s, ".mem_addr"},  64'(mem_addr[i]),  64'(sel ? dmem_addr[i] : imem_addr[i]));
        chk({s, ".mem_wen"},   64'(mem_wen[i]),   64'(sel ? dmem_wen[i] : 1'b0));
        chk({s, ".mem_strb"},  64'(mem_strb[i]),  64'(sel ? dmem_strb[i] : 4'b0));
        chk({s, ".mem_wdata"}, 64'(mem_wdata[i]), 64'(sel ? dmem_wdata[i] : 32'b0));
        chk({s, ".imem_gnt"},  64'(imem_gnt[i]),  64'(grant && !sel));
        chk({s, ".dmem_gnt"},  64'(dmem_gnt[i]),  64'(grant && sel));
        chk({s, ".mem_ack"},   64'(mem_ack[i]),   64'(ack));
        chk({s, ".imem_recv"}, 64'(imem_recv[i]), 64'(mem_recv[i] && occ && !head));
        chk({s, ".dmem_recv"}, 64'(dmem_recv[i]), 64'(mem_recv[i] && occ && head));
        chk({s, ".rdata"},     {imem_rdata[i], dmem_rdata[i]}, {mem_rdata[i], mem_rdata[i]});
        chk({s, ".err"},       64'({imem_error[i], dmem_error[i]}), 64'({mem_error[i], mem_error[i]}));

        pop = mem_recv[i] && ack;
        if (pop) begin
            for (int k = 0; k < 3; k++) m_q[i][k] = m_q[i][k+1];
            m_cnt[i]--;
        end
        if (grant) begin
            m_q[i][m_cnt[i]] = sel;
            m_cnt[i]++;
            m_lock[i] = -1;
            m_last[i] = sel;
            if (sel) pend_d[i] = 1'b0;
            else     pend_i[i] = 1'b0;
        end else if (mreq) begin
            m_lock[i] = sel ? 1 : 0;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            model_clear(i);
            for (int k = 0; k < 4; k++) m_q[i][k] = 1'b0;
            imem_req[i] = 1'b0; dmem_req[i] = 1'b0; dmem_wen[i] = 1'b0;
            dmem_strb[i] = 4'b0; dmem_wdata[i] = 32'b0; dmem_addr[i] = 32'b0;
            imem_addr[i] = 32'b0; mem_gnt[i] = 1'b0; mem_recv[i] = 1'b0;
            randomize_side(i);
        end

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc < 2 || $urandom_range(149, 0) == 0) begin
                // Reset with live-looking inputs: every output must still be 0.
                rst = 1'b1;
                for (int i = 0; i < 2; i++) begin
                    imem_req[i]  = 1'b1;
                    dmem_req[i]  = 1'b1;
                    dmem_wen[i]  = 1'b1;
                    dmem_strb[i] = 4'hf;
                    dmem_wdata[i] = $urandom;
                    dmem_addr[i] = $urandom;
                    imem_addr[i] = $urandom;
                    mem_gnt[i]   = 1'b1;
                    mem_recv[i]  = 1'b1;
                    randomize_side(i);
                    mem_error[i] = 1'b1;
                end
                #1;
                for (int i = 0; i < 2; i++) begin
                    check_reset(i);
                    model_clear(i);
                end
            end else begin
                rst = 1'b0;
                for (int i = 0; i < 2; i++) drive(i);
                #1;
                for (int i = 0; i < 2; i++) check_cycle(i);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/frv_mem_arbiter.md
FRV_MEM_ARBITER -- requirements
Module: frv_mem_arbiter

Interface
REQ-001 SHALL have parameter OUTSTANDING, default 2, max in-flight granted-but-unanswered transactions (1..4).
REQ-002 SHALL have parameter DATA_PRIORITY, default 1; 1 = fixed data priority, 0 = round-robin.
REQ-003 g_clk  in  1  sole clock, all state on rising edge.
REQ-004 g_reset  in  1  asynchronous, active-high reset.
REQ-005 imem_req  in  1  instruction fetch request (read-only requester).
REQ-006 imem_addr  in  32  fetch address.
REQ-007 imem_gnt  out  1  fetch request accepted.
REQ-008 imem_recv  out  1  fetch response valid.
REQ-009 imem_ack  in  1  fetch response accepted.
REQ-010 imem_error  out  1  fetch response error.
REQ-011 imem_rdata  out  32  fetch read data.
REQ-012 dmem_req  in  1  data request.
REQ-013 dmem_wen  in  1  data write enable.
REQ-014 dmem_strb  in  4  data write strobe.
REQ-015 dmem_wdata  in  32  data write data.
REQ-016 dmem_addr  in  32  data address.
REQ-017 dmem_gnt  out  1  data request accepted.
REQ-018 dmem_recv  out  1  data response valid.
REQ-019 dmem_ack  in  1  data response accepted.
REQ-020 dmem_error  out  1  data response error.
REQ-021 dmem_rdata  out  32  data read data.
REQ-022 mem_req, mem_wen, mem_strb[4], mem_wdata[32], mem_addr[32]  out  shared request port to the AXI adapter.
REQ-023 mem_gnt, mem_recv, mem_error, mem_rdata[32]  in  shared port grant/response; mem_ack  out  1  response accepted.

Function
REQ-024 Unlocked select: DATA_PRIORITY=1 -> dmem if dmem_req else imem; DATA_PRIORITY=0 -> on conflict the requester not granted last wins (last-grant register resets to imem, so dmem wins first conflict).
REQ-025 Lock: if mem_req=1 and mem_gnt=0, owner latched; the locked owner stays selected until the cycle mem_gnt=1 (lock clears that cycle); other requester cannot pre-empt.
REQ-026 mem_req = selected requester's req AND count<OUTSTANDING; mem_wen/strb/wdata/addr muxed from selected; imem selected drives wen=0, strb=0, wdata=0.
REQ-027 x_gnt = mem_gnt AND mem_req AND sel==x, combinational, zero-latency.
REQ-028 Owner FIFO (depth OUTSTANDING, 1-bit ID, 0=imem 1=dmem): push on mem_req&&mem_gnt, pop on mem_recv&&mem_ack; count 0..OUTSTANDING; push+pop same cycle keeps count.
REQ-029 Full (count==OUTSTANDING): mem_req forced 0, both gnt 0, lock not set.
REQ-030 Routing: x_recv = mem_recv AND count!=0 AND head==x; mem_ack = head owner's ack, 0 when empty; rdata/error broadcast to both requesters, meaningful only with recv.
REQ-031 mem_recv while count==0 SHALL be ignored: no recv asserted, mem_ack=0.
REQ-032 Downstream responses in order, earliest the cycle after grant; same-cycle grant/response not supported.

Reset
REQ-033 g_reset asserted: FIFO emptied, count=0, lock cleared, last-grant=imem; all outputs 0 during reset.
REQ-034 Reset mid-transaction abandons in-flight entries; later stray responses follow REQ-031.

Structure
REQ-035 Shared package frv_mem_pkg holds owner ID constants (OWNER_IMEM=0, OWNER_DMEM=1) and the OUTSTANDING max bound.
REQ-036 Owner FIFO SHALL be a sub-module frv_mem_owner_fifo (push, pop, head, count, full, empty).

Verification
REQ-037 Simultaneous imem_req/dmem_req, DATA_PRIORITY=1, mem_gnt=1 -> dmem_gnt=1, imem_gnt=0, FIFO head=1.
REQ-038 dmem_req, mem_gnt held 0 for 3 cycles, imem_req rises cycle 2 -> mem_addr stays dmem_addr; dmem_gnt on cycle gnt rises.
REQ-039 OUTSTANDING=2, two fetches granted, no responses -> third request sees mem_req=0 until mem_recv&&imem_ack.
REQ-040 Responses for grants imem then dmem, rdata 0x11 then 0x22 -> imem_recv with 0x11, then dmem_recv with 0x22; dmem_ack ignored during first.
REQ-041 mem_recv=1, count=0 -> imem_recv=dmem_recv=mem_ack=0.
REQ-042 g_reset asserted with count=2 mid-lock -> all outputs 0 immediately; after release count=0, next conflict granted per REQ-024.
